// File: rtl/dcache_req_arbiter_pkg.sv
// Shared types for the data-cache request arbiter: cache op encodings,
// arbiter FSM states and the captured request payload.
package dcache_req_arbiter_pkg;

    localparam int DATA_SIZE  = 32;
    localparam int REQ_ADDR_W = 32;

    typedef enum logic [1:0] {
        SOP_SB = 2'd0,
        SOP_SH = 2'd1,
        SOP_SW = 2'd2
    } t_sop;

    typedef enum logic [2:0] {
        LDOP_LB  = 3'd0,
        LDOP_LH  = 3'd1,
        LDOP_LW  = 3'd2,
        LDOP_LBU = 3'd3,
        LDOP_LHU = 3'd4
    } t_ldop;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } t_arb_state;

    typedef struct packed {
        logic                  write;
        logic [REQ_ADDR_W-1:0] addr;
        logic [DATA_SIZE-1:0]  store_data;
        t_sop                  sop;
        t_ldop                 ldop;
    } dcache_req_t;

    // Index width for an N-entry vector; a single entry still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dcache_req_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found when
// searching upward (with wrap) from the round-robin pointer.
module rr_arbiter
    import dcache_req_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_any
);

    int                 w_idx;
    logic [NUM_REQ-1:0] w_shift;

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_idx       = 0;
        w_shift     = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_idx   = (int'(i_rr_ptr) + off) % NUM_REQ;
            w_shift = i_req >> w_idx;
            if (!o_any && w_shift[0]) begin
                o_any       = 1'b1;
                o_grant     = NUM_REQ'(1) << w_idx;
                o_grant_idx = IDX_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/dcache_req_arbiter.sv
// Shares one data_cache request port between NUM_REQ requesters with a
// round-robin grant, one transaction in flight, and a sticky stall watchdog.
module dcache_req_arbiter
    import dcache_req_arbiter_pkg::*;
#(
    parameter  int NUM_REQ        = 2,
    parameter  int ADDR_SIZE      = 32,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int OWNER_W        = idx_width(NUM_REQ)
) (
    input  logic                 i_aclk,
    input  logic                 i_areset_n,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [NUM_REQ-1:0]   i_req_write,
    input  logic [ADDR_SIZE-1:0] i_addr       [NUM_REQ],
    input  logic [DATA_SIZE-1:0] i_store_data [NUM_REQ],
    input  t_sop                 i_sop        [NUM_REQ],
    input  t_ldop                i_ldop       [NUM_REQ],
    output logic [NUM_REQ-1:0]   o_req_ready,
    output logic [NUM_REQ-1:0]   o_data_valid,
    output logic [DATA_SIZE-1:0] o_data,
    output logic                 o_cache_req,
    output logic                 o_cache_req_write,
    output logic [ADDR_SIZE-1:0] o_cache_addr,
    output logic [DATA_SIZE-1:0] o_cache_store_data,
    output t_sop                 o_cache_sop,
    output t_ldop                o_cache_ldop,
    input  logic                 i_cache_req_ready,
    input  logic                 i_cache_data_valid,
    input  logic [DATA_SIZE-1:0] i_cache_data,
    output logic [OWNER_W-1:0]   o_owner,
    output logic                 o_busy,
    output logic                 o_timeout
);

    localparam int WD_MAX = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 1;
    localparam int WD_W   = $clog2(WD_MAX + 1);

    t_arb_state           r_state;
    t_arb_state           w_state_next;
    dcache_req_t          r_payload;
    logic [OWNER_W-1:0]   r_owner;
    logic [OWNER_W-1:0]   r_rr_ptr;
    logic [NUM_REQ-1:0]   r_data_valid;
    logic [DATA_SIZE-1:0] r_data;
    logic [WD_W-1:0]      r_wd_cnt;
    logic                 r_timeout;

    logic [NUM_REQ-1:0]   w_grant;
    logic [OWNER_W-1:0]   w_grant_idx;
    logic                 w_any;
    logic                 w_accept;
    logic                 w_complete;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req       (i_req),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_complete   = 1'b0;
        o_req_ready  = '0;
        case (r_state)
            ARB_IDLE: begin
                // Ready is masked in reset so no requester sees an accept that is then dropped.
                if (i_areset_n) o_req_ready = w_grant;
                if (w_any) begin
                    w_accept     = 1'b1;
                    w_state_next = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (i_cache_req_ready) begin
                    if (i_cache_data_valid) begin
                        w_complete   = 1'b1;
                        w_state_next = ARB_IDLE;
                    end else begin
                        w_state_next = ARB_WAIT;
                    end
                end
            end
            ARB_WAIT: begin
                if (i_cache_data_valid) begin
                    w_complete   = 1'b1;
                    w_state_next = ARB_IDLE;
                end
            end
            default: w_state_next = ARB_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_aclk) begin
        if (!i_areset_n) r_state <= ARB_IDLE;
        else             r_state <= w_state_next;
    end

    always_ff @(posedge i_aclk) begin
        if (!i_areset_n) begin
            r_payload    <= '0;
            r_owner      <= '0;
            r_rr_ptr     <= '0;
            r_data_valid <= '0;
            r_data       <= '0;
        end else begin
            if (w_accept) begin
                r_payload.write      <= i_req_write[w_grant_idx];
                r_payload.addr       <= REQ_ADDR_W'(i_addr[w_grant_idx]);
                r_payload.store_data <= i_store_data[w_grant_idx];
                r_payload.sop        <= i_sop[w_grant_idx];
                r_payload.ldop       <= i_ldop[w_grant_idx];
                r_owner              <= w_grant_idx;
            end
            r_data_valid <= w_complete ? (NUM_REQ'(1) << r_owner) : '0;
            if (w_complete) begin
                r_data   <= i_cache_data;
                r_rr_ptr <= (r_owner == OWNER_W'(NUM_REQ - 1)) ? '0 : r_owner + OWNER_W'(1);
            end
        end
    end

    // Watchdog counts every busy cycle from issue and saturates at the limit.
    always_ff @(posedge i_aclk) begin
        if (!i_areset_n) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wd_cnt <= '0;
            end else if (r_state != ARB_IDLE && r_wd_cnt != WD_W'(WD_MAX)) begin
                r_wd_cnt <= r_wd_cnt + WD_W'(1);
            end
            if (TIMEOUT_CYCLES != 0 && r_state != ARB_IDLE && r_wd_cnt == WD_W'(WD_MAX - 1)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign o_cache_req        = (r_state == ARB_ISSUE);
    assign o_cache_req_write  = r_payload.write;
    assign o_cache_addr       = r_payload.addr[ADDR_SIZE-1:0];
    assign o_cache_store_data = r_payload.store_data;
    assign o_cache_sop        = r_payload.sop;
    assign o_cache_ldop       = r_payload.ldop;
    assign o_data_valid       = r_data_valid;
    assign o_data             = r_data;
    assign o_owner            = r_owner;
    assign o_busy             = (r_state != ARB_IDLE);
    assign o_timeout          = r_timeout;

endmodule
